// File: rtl/vga_seq_pkg.sv
// Shared types and default 640x480@60 timing for the VGA pattern sequencer.
//   pattern_t    : test pattern selector (BARS, CHECKER, RAMP, SOLID)
//   rgb12_t      : packed {r[3:0], g[3:0], b[3:0]} pixel colour
//   Def*         : default raster timing, in pixels (horizontal) and lines (vertical)
//   pattern_succ : next pattern in the cyclic sequence
package vga_seq_pkg;

    // Counter and coordinate width; sized for H_TOTAL = 800.
    localparam int unsigned CntW = 10;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    typedef enum logic [1:0] {
        BARS    = 2'd0,
        CHECKER = 2'd1,
        RAMP    = 2'd2,
        SOLID   = 2'd3
    } pattern_t;

    typedef logic [11:0] rgb12_t;

    function automatic pattern_t pattern_succ(input pattern_t p);
        logic [1:0] v;
        v = p;
        v = v + 2'd1;
        return pattern_t'(v);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters plus registered sync, active, x/y and
// frame_start. Every registered output is loaded from the next-count values, so outputs always
// describe the pixel the counters currently point at.
// Ports:
//   clk_i, rst_i (sync, active-high), pix_en_i (pixel-clock enable)
//   hsync_o, vsync_o, active_o, x_o, y_o, frame_start_o : registered raster outputs
//   h_next_o, v_next_o, active_next_o, wrap_next_o     : next-state values, so the parent can
//                                                        register its own outputs in step
module vga_timing_gen
    import vga_seq_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pix_en_i,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            active_o,
    output logic [CntW-1:0] x_o,
    output logic [CntW-1:0] y_o,
    output logic            frame_start_o,
    output logic [CntW-1:0] h_next_o,
    output logic [CntW-1:0] v_next_o,
    output logic            active_next_o,
    output logic            wrap_next_o
);

    localparam logic [CntW-1:0] HLast     = CntW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CntW-1:0] VLast     = CntW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CntW-1:0] HActEnd   = CntW'(H_ACTIVE);
    localparam logic [CntW-1:0] VActEnd   = CntW'(V_ACTIVE);
    localparam logic [CntW-1:0] HSyncBeg  = CntW'(H_ACTIVE + H_FP);
    localparam logic [CntW-1:0] HSyncEnd  = CntW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CntW-1:0] VSyncBeg  = CntW'(V_ACTIVE + V_FP);
    localparam logic [CntW-1:0] VSyncEnd  = CntW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CntW-1:0] hcount_q, hcount_d;
    logic [CntW-1:0] vcount_q, vcount_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            active_q, active_d;
    logic [CntW-1:0] x_q, y_q;
    logic            frame_start_q;
    logic            wrap_d;

    always_comb begin
        hcount_d = (hcount_q == HLast) ? '0 : hcount_q + CntW'(1);
        vcount_d = vcount_q;
        if (hcount_q == HLast) begin
            vcount_d = (vcount_q == VLast) ? '0 : vcount_q + CntW'(1);
        end
        hsync_d  = ((hcount_d >= HSyncBeg) && (hcount_d < HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        vsync_d  = ((vcount_d >= VSyncBeg) && (vcount_d < VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
        active_d = (hcount_d < HActEnd) && (vcount_d < VActEnd);
        wrap_d   = (hcount_d == '0) && (vcount_d == '0);
    end

    // Reset parks the counters on the last back-porch pixel so the first enabled
    // pixel after release is (0,0) with frame_start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount_q      <= HLast;
            vcount_q      <= VLast;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else if (pix_en_i) begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            x_q           <= hcount_d;
            y_q           <= vcount_d;
            frame_start_q <= wrap_d;
        end else begin
            frame_start_q <= 1'b0;
        end
    end

    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign active_o      = active_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign frame_start_o = frame_start_q;
    assign h_next_o      = hcount_d;
    assign v_next_o      = vcount_d;
    assign active_next_o = active_d;
    assign wrap_next_o   = wrap_d;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern sequencer: raster timing (vga_timing_gen) plus the pattern FSM, frame
// counter, bar sub-counter and registered 12-bit RGB mux. Pattern only changes on frame_start.
// Ports:
//   clk_i, rst_i (sync, active-high), pix_en_i (pixel-clock enable)
//   next_pattern_i : manual advance request, present only with VGA_SEQ_MANUAL_EN
//   hsync_o, vsync_o, active_o, x_o, y_o, frame_start_o : raster outputs
//   pattern_o      : 0 BARS, 1 CHECKER, 2 RAMP, 3 SOLID
//   rgb_o          : {r,g,b} 4 bits each, zero outside the active area
// Build option: define VGA_SEQ_MANUAL_EN to advance the pattern from next_pattern_i instead of
// every FRAMES_PER_PATTERN frames.
module vga_pattern_sequencer
    import vga_seq_pkg::*;
#(
    parameter int unsigned H_ACTIVE           = DefHActive,
    parameter int unsigned H_FP               = DefHFp,
    parameter int unsigned H_SYNC             = DefHSync,
    parameter int unsigned H_BP               = DefHBp,
    parameter int unsigned V_ACTIVE           = DefVActive,
    parameter int unsigned V_FP               = DefVFp,
    parameter int unsigned V_SYNC             = DefVSync,
    parameter int unsigned V_BP               = DefVBp,
    parameter bit          SYNC_POL           = 1'b0,
    parameter int unsigned FRAMES_PER_PATTERN = 60
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            pix_en_i,
`ifdef VGA_SEQ_MANUAL_EN
    input  logic            next_pattern_i,
`endif
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            active_o,
    output logic [CntW-1:0] x_o,
    output logic [CntW-1:0] y_o,
    output logic            frame_start_o,
    output logic [1:0]      pattern_o,
    output logic [11:0]     rgb_o
);

    localparam logic [CntW-1:0] BarLast = CntW'(H_ACTIVE / 8 - 1);

    logic [CntW-1:0] h_next, v_next;
    logic            active_next, wrap_next, frame_edge, advance;
    pattern_t        pattern_q, pattern_d;
    logic [CntW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]      bar_idx_q, bar_idx_d;
    rgb12_t          rgb_q, rgb_d;
    logic            unused_v_next;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .pix_en_i      (pix_en_i),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .active_o      (active_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .frame_start_o (frame_start_o),
        .h_next_o      (h_next),
        .v_next_o      (v_next),
        .active_next_o (active_next),
        .wrap_next_o   (wrap_next)
    );

    // Only bit 5 of the vertical count feeds the checker.
    assign unused_v_next = ^{v_next[CntW-1:6], v_next[4:0]};

    // The edge that raises frame_start.
    assign frame_edge = pix_en_i & wrap_next;

`ifdef VGA_SEQ_MANUAL_EN
    logic pending_q, pending_d;

    // A request landing on the frame_start edge itself is kept for the next frame.
    always_comb begin
        pending_d = pending_q;
        advance   = 1'b0;
        if (frame_edge) begin
            advance   = pending_q;
            pending_d = 1'b0;
        end
        if (next_pattern_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    localparam int unsigned FcW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
    localparam logic [FcW-1:0] FcLast = FcW'(FRAMES_PER_PATTERN - 1);

    logic           started_q, started_d;
    logic [FcW-1:0] frame_cnt_q, frame_cnt_d;

    // The first frame_start after reset opens frame 0 and never advances the pattern;
    // later ones count frames and advance on every FRAMES_PER_PATTERN-th.
    always_comb begin
        started_d   = started_q;
        frame_cnt_d = frame_cnt_q;
        advance     = 1'b0;
        if (frame_edge) begin
            started_d = 1'b1;
            if (!started_q) begin
                frame_cnt_d = '0;
            end else if (frame_cnt_q == FcLast) begin
                frame_cnt_d = '0;
                advance     = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + FcW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            started_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            started_q   <= started_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
`endif

    assign pattern_d = advance ? pattern_succ(pattern_q) : pattern_q;

    // Bar index tracks h_next by counting bar-width runs, restarted at h = 0.
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (h_next == '0) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == BarLast) begin
            bar_cnt_d = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end else begin
            bar_cnt_d = bar_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        rgb_d = '0;
        if (active_next) begin
            unique case (pattern_d)
                BARS:    rgb_d = {{4{bar_idx_d[2]}}, {4{bar_idx_d[1]}}, {4{bar_idx_d[0]}}};
                CHECKER: rgb_d = (h_next[5] ^ v_next[5]) ? 12'hFFF : 12'h000;
                RAMP:    rgb_d = {3{h_next[9:6]}};
                SOLID:   rgb_d = 12'hFFF;
                default: rgb_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pattern_q <= BARS;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            rgb_q     <= '0;
        end else if (pix_en_i) begin
            pattern_q <= pattern_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign pattern_o = pattern_q;
    assign rgb_o     = rgb_q;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Scoreboard bench for vga_pattern_sequencer on a shortened raster (656 x 6, 640 x 2 visible).
// Expected values are keyed by output index (count of enabled pixels since reset release) and
// popped by a monitor as the DUT produces each pixel.
module tb_vga_pattern_sequencer;

    localparam int HA = 640, HF = 4, HS = 8, HB = 4;
    localparam int VA = 2, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int FPP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;
    logic        hsync, vsync, active, frame_start;
    logic [9:0]  x, y;
    logic [1:0]  pattern;
    logic [11:0] rgb;
`ifdef VGA_SEQ_MANUAL_EN
    logic        next_pattern = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_pattern_sequencer #(
        .H_ACTIVE           (HA),
        .H_FP               (HF),
        .H_SYNC             (HS),
        .H_BP               (HB),
        .V_ACTIVE           (VA),
        .V_FP               (VF),
        .V_SYNC             (VS),
        .V_BP               (VB),
        .SYNC_POL           (1'b0),
        .FRAMES_PER_PATTERN (FPP)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pix_en_i       (pix_en),
`ifdef VGA_SEQ_MANUAL_EN
        .next_pattern_i (next_pattern),
`endif
        .hsync_o        (hsync),
        .vsync_o        (vsync),
        .active_o       (active),
        .x_o            (x),
        .y_o            (y),
        .frame_start_o  (frame_start),
        .pattern_o      (pattern),
        .rgb_o          (rgb)
    );

    typedef enum int {SigX, SigY, SigFs, SigPat, SigRgb, SigAct, SigHs, SigVs} sig_e;
    typedef struct {
        int          idx;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   gi = 0;
    int   n_out = 0;
    bit   stats_on = 1'b0;
    int   st_act = 0, st_hs = 0, st_hs0 = 0, st_vs = 0, st_fs = 0, pat_viol = 0;
    int   pat_exp[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sig_value(input sig_e s);
        case (s)
            SigX:    return 32'(x);
            SigY:    return 32'(y);
            SigFs:   return 32'(frame_start);
            SigPat:  return 32'(pattern);
            SigRgb:  return 32'(rgb);
            SigAct:  return 32'(active);
            SigHs:   return 32'(hsync);
            default: return 32'(vsync);
        endcase
    endfunction

    task automatic expect_at(input int idx, input sig_e s, input logic [31:0] v);
        exp_t it;
        int   pos;
        it.idx = idx;
        it.sig = s;
        it.exp = v;
        pos = sb.size();
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].idx > idx) begin
                pos = k;
                break;
            end
        end
        sb.insert(pos, it);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(x), 0);
        check({tag, "_y"}, 32'(y), 0);
        check({tag, "_fs"}, 32'(frame_start), 0);
        check({tag, "_pattern"}, 32'(pattern), 0);
        check({tag, "_rgb"}, 32'(rgb), 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_active"}, 32'(active), 0);
    endtask

    // One enabled pixel per iteration; manual-advance pulses are keyed to output indices.
    task automatic run(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            pix_en = 1'b1;
`ifdef VGA_SEQ_MANUAL_EN
            next_pattern = (gi == 100) || (gi == 200) || (gi == 300) || (gi == 2 * FT);
`endif
            @(negedge clk);
            gi++;
        end
`ifdef VGA_SEQ_MANUAL_EN
        next_pattern = 1'b0;
`endif
    endtask

    // Monitor: after every enabled edge, pop and compare the expectations for that pixel.
    initial begin
        logic       s_rst, s_en;
        logic [1:0] prev_pat;
        exp_t       e;
        prev_pat = 2'd0;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_en  = pix_en;
            #1;
            if (s_rst) begin
                n_out    = 0;
                prev_pat = pattern;
            end else if (s_en) begin
                while (sb.size() > 0 && sb[0].idx == n_out) begin
                    e = sb.pop_front();
                    check($sformatf("%s@%0d", e.sig.name(), e.idx), sig_value(e.sig), e.exp);
                end
                if (pattern !== prev_pat && frame_start !== 1'b1) pat_viol++;
                prev_pat = pattern;
                if (stats_on) begin
                    if (frame_start === 1'b1) st_fs++;
                    if (n_out < FT) begin
                        if (active === 1'b1) st_act++;
                        if (hsync === 1'b0) st_hs++;
                        if (hsync === 1'b0 && n_out < HT) st_hs0++;
                        if (vsync === 1'b0) st_vs++;
                    end
                end
                n_out++;
            end
        end
    end

    initial begin
`ifdef VGA_SEQ_MANUAL_EN
        pat_exp = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 2, 2};
`else
        pat_exp = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
`endif
        rst    = 1'b1;
        pix_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        for (int f = 0; f < 11; f++) begin
            expect_at(f * FT, SigFs, 1);
            expect_at(f * FT, SigPat, pat_exp[f]);
            expect_at(f * FT + 1, SigFs, 0);
        end
        expect_at(0, SigX, 0);
        expect_at(0, SigY, 0);
        expect_at(1, SigX, 1);
        expect_at(79, SigRgb, 12'h000);
        expect_at(80, SigX, 80);
        expect_at(80, SigRgb, 12'h00F);
        expect_at(160, SigRgb, 12'h0F0);
        expect_at(400, SigRgb, 12'hF0F);
        expect_at(639, SigRgb, 12'hFFF);
        expect_at(639, SigAct, 1);
        expect_at(640, SigRgb, 12'h000);
        expect_at(640, SigAct, 0);
        expect_at(643, SigHs, 1);
        expect_at(644, SigHs, 0);
        expect_at(651, SigHs, 0);
        expect_at(652, SigHs, 1);
        expect_at(HT, SigX, 0);
        expect_at(HT, SigY, 1);
        expect_at(HT, SigAct, 1);
        expect_at(2 * HT, SigAct, 0);
        expect_at(3 * HT - 1, SigVs, 1);
        expect_at(3 * HT, SigVs, 0);
        expect_at(5 * HT - 1, SigVs, 0);
        expect_at(5 * HT, SigVs, 1);
`ifdef VGA_SEQ_MANUAL_EN
        expect_at(3 * FT + 320, SigRgb, 12'h555);
`else
        expect_at(2 * FT + 31, SigRgb, 12'h000);
        expect_at(2 * FT + 32, SigRgb, 12'hFFF);
        expect_at(2 * FT + 64, SigRgb, 12'h000);
        expect_at(4 * FT + 320, SigRgb, 12'h555);
        expect_at(4 * FT + 639, SigRgb, 12'h999);
        expect_at(4 * FT + 640, SigRgb, 12'h000);
        expect_at(6 * FT + 100, SigRgb, 12'hFFF);
        expect_at(6 * FT + HT + 5, SigRgb, 12'hFFF);
        expect_at(6 * FT + 2 * HT + 5, SigRgb, 12'h000);
        expect_at(8 * FT + 80, SigRgb, 12'h00F);
`endif

        // Release, one enabled pixel, then two disabled cycles that must freeze outputs.
        stats_on = 1'b1;
        rst      = 1'b0;
        run(1);
        for (int k = 0; k < 2; k++) begin
            pix_en = 1'b0;
            @(negedge clk);
            check($sformatf("hold%0d_fs", k), 32'(frame_start), 0);
            check($sformatf("hold%0d_x", k), 32'(x), 0);
            check($sformatf("hold%0d_y", k), 32'(y), 0);
            check($sformatf("hold%0d_active", k), 32'(active), 1);
        end

        // Run up to pixel (300,1) of frame 10.
        run(10 * FT + HT + 300 + 1 - gi);
        stats_on = 1'b0;
        check("pre_rst_x", 32'(x), 300);
        check("pre_rst_y", 32'(y), 1);
        check("frame0_active_cycles", st_act, HA * VA);
        check("frame0_hsync_low", st_hs, HS * VT);
        check("line0_hsync_low", st_hs0, HS);
        check("frame0_vsync_low", st_vs, VS * HT);
        check("frame_start_count", st_fs, 11);
        check("pattern_change_off_frame_start", pat_viol, 0);
        check("scoreboard_drained", sb.size(), 0);

        // Mid-frame reset with pix_en held high.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("midrst");
        expect_at(0, SigFs, 1);
        expect_at(0, SigX, 0);
        expect_at(0, SigY, 0);
        expect_at(0, SigPat, 0);
        expect_at(1, SigFs, 0);
        rst = 1'b0;
        gi  = 0;
        run(2);
        pix_en = 1'b0;
        @(negedge clk);
        check("scoreboard_drained_after_rst", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
